branch_resolver: RTL and testbench

Resolve-side partner of the fetch-stage branch predictor. Fetch pushes each fetched instruction's PC and predicted next PC into a small in-order prediction queue. The EX stage pops one entry per executed instruction, evaluates the branch condition, and compares the predicted next PC with the actual one. On a mismatch the block raises a one-cycle flush with the redirect PC and sends a BTB/counter update back to the predictor.

---
 rtl/branch_resolver.sv | 165 ++++++++++++++++
 tb/tb_branch_resolver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Resolve-side branch checker: in-order prediction queue, condition evaluation, flush and predictor update.
// Optional statistics counters are built only when BR_STATS_EN is defined.
module branch_resolver #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [15:0] fetch_PC,
   input  logic [15:0] fetch_pred_PC,
   input  logic        ex_valid,
   input  logic [15:0] ex_instr,
   input  logic [15:0] ex_PC,
   input  logic [15:0] read_out1,
   input  logic [15:0] read_out2,
   input  logic [15:0] Imm,
   output logic        flush,
   output logic [15:0] redirect_PC,
   output logic        update_valid,
   output logic [15:0] update_PC,
   output logic [15:0] update_target,
   output logic        update_taken,
   output logic        sync_err,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic {RUN, FLUSH} state_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] pred;
   } entry_t;

   typedef enum logic [3:0] {
      OP_BNE = 4'd0,
      OP_BEQ = 4'd1,
      OP_BGZ = 4'd2,
      OP_BLZ = 4'd3
   } opcode_t;

   state_t      state;
   entry_t      mem [DEPTH];
   logic [AW:0] wptr, rptr;
   entry_t      head;

   logic        empty, full;
   logic        pop_fire, pop_ok, push_fire;
   logic        is_branch, taken;
   logic [15:0] target, seq_pc, actual_pc;
   logic        mispredict, do_update, sync_hit;
   logic        unused_instr_bits;

   assign unused_instr_bits = ^ex_instr[11:0];

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign head  = mem[rptr[AW-1:0]];

   assign fetch_ready = (state == RUN) && !full;

   // A pop frees the slot in the same cycle, so a push is still accepted while full.
   assign pop_fire  = ex_valid && (state == RUN);
   assign pop_ok    = pop_fire && !empty;
   assign push_fire = fetch_valid && (state == RUN) && (!full || pop_fire);

   assign is_branch = (ex_instr[15:14] == 2'b00);
   assign target    = ex_PC + Imm;
   assign seq_pc    = ex_PC + 16'd1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      taken = 1'b0;
      case (opcode_t'(ex_instr[15:12]))
         OP_BNE:  taken = (read_out1 != read_out2);
         OP_BEQ:  taken = (read_out1 == read_out2);
         OP_BGZ:  taken = ($signed(read_out1) > 16'sd0);
         OP_BLZ:  taken = read_out1[15];
         default: taken = 1'b0;
      endcase
   end

   assign actual_pc  = (is_branch && taken) ? target : seq_pc;
   assign mispredict = pop_ok && (head.pred != actual_pc);
   assign do_update  = pop_ok && (is_branch || (head.pred != seq_pc));
   assign sync_hit   = pop_fire && (empty || (ex_PC != head.pc));

   // NOTE: the queue storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push_fire && !mispredict) begin
         mem[wptr[AW-1:0]] <= '{pc: fetch_PC, pred: fetch_pred_PC};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= RUN;
         wptr          <= '0;
         rptr          <= '0;
         flush         <= 1'b0;
         redirect_PC   <= '0;
         update_valid  <= 1'b0;
         update_PC     <= '0;
         update_target <= '0;
         update_taken  <= 1'b0;
         sync_err      <= 1'b0;
      end else begin
         flush         <= 1'b0;
         redirect_PC   <= '0;
         update_valid  <= 1'b0;
         update_PC     <= '0;
         update_target <= '0;
         update_taken  <= 1'b0;
         case (state)
            RUN: begin
               if (mispredict) begin
                  state       <= FLUSH;
                  flush       <= 1'b1;
                  redirect_PC <= actual_pc;
                  wptr        <= '0;
                  rptr        <= '0;
               end else begin
                  if (push_fire) wptr <= wptr + PTR_ONE;
                  if (pop_ok)    rptr <= rptr + PTR_ONE;
               end
               if (do_update) begin
                  update_valid  <= 1'b1;
                  update_PC     <= ex_PC;
                  update_target <= is_branch ? target : seq_pc;
                  update_taken  <= is_branch && taken;
               end
               if (sync_hit) sync_err <= 1'b1;
            end
            FLUSH: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef BR_STATS_EN
   logic [15:0] br_cnt, mp_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_cnt <= '0;
         mp_cnt <= '0;
      end else begin
         if (pop_ok && is_branch && (br_cnt != 16'hFFFF)) br_cnt <= br_cnt + 16'd1;
         if (mispredict && (mp_cnt != 16'hFFFF))          mp_cnt <= mp_cnt + 16'd1;
      end
   end

   assign branch_count     = br_cnt;
   assign mispredict_count = mp_cnt;
`else
   assign branch_count     = '0;
   assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: stimulus queues expected resolve pulses, a monitor compares them.
module tb_branch_resolver;

   typedef struct packed {
      logic        flush;
      logic [15:0] redirect;
      logic        uvalid;
      logic [15:0] upc;
      logic [15:0] utarget;
      logic        utaken;
   } resp_t;

   logic        clk, reset_n;
   logic        fetch_valid, fetch_ready;
   logic [15:0] fetch_PC, fetch_pred_PC;
   logic        ex_valid;
   logic [15:0] ex_instr, ex_PC, read_out1, read_out2, Imm;
   logic        flush;
   logic [15:0] redirect_PC;
   logic        update_valid;
   logic [15:0] update_PC, update_target;
   logic        update_taken;
   logic        sync_err;
   logic [15:0] branch_count, mispredict_count;

   int    checks = 0;
   int    errors = 0;
   resp_t sb[$];

   branch_resolver #(.DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_PC(fetch_PC), .fetch_pred_PC(fetch_pred_PC),
      .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_PC(ex_PC),
      .read_out1(read_out1), .read_out2(read_out2), .Imm(Imm),
      .flush(flush), .redirect_PC(redirect_PC),
      .update_valid(update_valid), .update_PC(update_PC),
      .update_target(update_target), .update_taken(update_taken),
      .sync_err(sync_err),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && (flush || update_valid)) begin
         resp_t act;
         act = '{flush, redirect_PC, update_valid, update_PC, update_target, update_taken};
         if (sb.size() == 0) check("unexpected_output", 64'(act), 64'd0);
         else                check("resolve_output", 64'(act), 64'(sb.pop_front()));
      end
   end

   task automatic expect_out(input logic f, input logic [15:0] redir, input logic [15:0] upc,
                             input logic [15:0] utgt, input logic utk);
      sb.push_back('{f, redir, 1'b1, upc, utgt, utk});
   endtask

   // One clock cycle of stimulus; returns #1 after the edge that sampled it.
   task automatic issue(input logic push, input logic [15:0] pc, input logic [15:0] pred,
                        input logic pop, input logic [15:0] instr, input logic [15:0] epc,
                        input logic [15:0] op1, input logic [15:0] op2, input logic [15:0] imm);
      fetch_valid = push; fetch_PC = pc; fetch_pred_PC = pred;
      ex_valid = pop; ex_instr = instr; ex_PC = epc;
      read_out1 = op1; read_out2 = op2; Imm = imm;
      @(posedge clk); #1;
      fetch_valid = 1'b0; ex_valid = 1'b0;
   endtask

   task automatic push_only(input logic [15:0] pc, input logic [15:0] pred);
      issue(1'b1, pc, pred, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic idle();
      issue(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   localparam logic [15:0] I_BNE = 16'h0000, I_BEQ = 16'h1000, I_BGZ = 16'h2000,
                           I_BLZ = 16'h3000, I_ADD = 16'h4000;
   localparam logic [15:0] EXP_BR = 16'd3
`ifdef BR_STATS_EN
   ;
   localparam logic [15:0] EXP_MP = 16'd1;
`else
   - 16'd3;
   localparam logic [15:0] EXP_MP = 16'd0;
`endif

   initial begin
      reset_n = 1'b0;
      fetch_valid = 1'b0; fetch_PC = '0; fetch_pred_PC = '0;
      ex_valid = 1'b0; ex_instr = '0; ex_PC = '0;
      read_out1 = '0; read_out2 = '0; Imm = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {flush, update_valid, update_taken, sync_err, redirect_PC, update_PC, update_target}, 64'd0);
      check("reset_counts", {branch_count, mispredict_count}, 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", fetch_ready, 64'd1);

      // Non-branch with correct prediction: silent.
      push_only(16'h0010, 16'h0011);
      issue(1'b0, 0, 0, 1'b1, I_ADD, 16'h0010, 0, 0, 0);
      check("add_no_sync_err", sync_err, 64'd0);

      // BEQ taken, predicted fall-through: flush.
      push_only(16'h0020, 16'h0021);
      expect_out(1'b1, 16'h0024, 16'h0020, 16'h0024, 1'b1);
      issue(1'b0, 0, 0, 1'b1, I_BEQ, 16'h0020, 16'h0005, 16'h0005, 16'h0004);
      check("ready_during_flush", fetch_ready, 64'd0);
      idle();
      check("ready_after_flush", fetch_ready, 64'd1);

      // BLZ taken backwards, correctly predicted.
      push_only(16'h0030, 16'h002E);
      expect_out(1'b0, 16'h0000, 16'h0030, 16'h002E, 1'b1);
      issue(1'b0, 0, 0, 1'b1, I_BLZ, 16'h0030, 16'hFFFF, 16'h0000, 16'hFFFE);

      // BNE not taken: target still reported as PC+Imm.
      push_only(16'h0040, 16'h0041);
      expect_out(1'b0, 16'h0000, 16'h0040, 16'h0050, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_BNE, 16'h0040, 16'h0007, 16'h0007, 16'h0010);

      // BGZ with zero operand: not taken.
      push_only(16'h0068, 16'h0069);
      expect_out(1'b0, 16'h0000, 16'h0068, 16'h006B, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_BGZ, 16'h0068, 16'h0000, 16'h0000, 16'h0003);

      // BGZ with most-negative operand, predicted taken: mispredict to PC+1.
      push_only(16'h0060, 16'h0065);
      expect_out(1'b1, 16'h0061, 16'h0060, 16'h0065, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_BGZ, 16'h0060, 16'h8000, 16'h0000, 16'h0005);
      idle();

      // Stale BTB hit on a non-branch.
      push_only(16'h0070, 16'h0090);
      expect_out(1'b1, 16'h0071, 16'h0070, 16'h0071, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_ADD, 16'h0070, 0, 0, 0);
      idle();

      // Fill, swap while full, then drain back-to-back across the pointer wrap.
      for (int i = 0; i < 4; i++) push_only(16'h0100 + 16'(i), 16'h0101 + 16'(i));
      check("full_not_ready", fetch_ready, 64'd0);
      issue(1'b1, 16'h0104, 16'h0105, 1'b1, I_ADD, 16'h0100, 0, 0, 0);
      check("full_after_swap", fetch_ready, 64'd0);
      for (int i = 1; i <= 4; i++) begin
         expect_out(1'b0, 16'h0000, 16'h0100 + 16'(i), 16'h0120 + 16'(i), 1'b0);
         issue(1'b0, 0, 0, 1'b1, I_BNE, 16'h0100 + 16'(i), 16'h0003, 16'h0003, 16'h0020);
      end
      check("drained_ready", fetch_ready, 64'd1);
      check("fifo_order_sync", sync_err, 64'd0);

      // Mispredict with a same-cycle push; wrong-path activity during FLUSH is ignored.
      push_only(16'h0200, 16'h0205);
      expect_out(1'b1, 16'h0202, 16'h0200, 16'h0202, 1'b1);
      issue(1'b1, 16'h0300, 16'h0301, 1'b1, I_BEQ, 16'h0200, 16'h0001, 16'h0001, 16'h0002);
      issue(1'b1, 16'h0400, 16'h0401, 1'b1, I_BEQ, 16'h0300, 16'h0009, 16'h0009, 16'h0008);
      check("flush_ignores_ex", sync_err, 64'd0);
      issue(1'b0, 0, 0, 1'b1, I_ADD, 16'h0300, 0, 0, 0);
      check("empty_pop_sync_err", sync_err, 64'd1);
      idle();
      check("sync_err_sticky", sync_err, 64'd1);

      // Fresh reset, then statistics: three branches, one mispredict.
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("sync_err_cleared", sync_err, 64'd0);
      push_only(16'h0500, 16'h0501);
      push_only(16'h0510, 16'h0511);
      push_only(16'h0520, 16'h0521);
      expect_out(1'b0, 16'h0000, 16'h0500, 16'h0510, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_BEQ, 16'h0500, 16'h0001, 16'h0002, 16'h0010);
      expect_out(1'b0, 16'h0000, 16'h0510, 16'h0520, 1'b0);
      issue(1'b0, 0, 0, 1'b1, I_BNE, 16'h0510, 16'h0001, 16'h0001, 16'h0010);
      expect_out(1'b1, 16'h0524, 16'h0520, 16'h0524, 1'b1);
      issue(1'b0, 0, 0, 1'b1, I_BGZ, 16'h0520, 16'h0001, 16'h0000, 16'h0004);
      idle();
      check("branch_count", branch_count, 64'(EXP_BR));
      check("mispredict_count", mispredict_count, 64'(EXP_MP));

      // Reset asserted inside the flush cycle, before the monitor samples it.
      push_only(16'h0600, 16'h0602);
      push_only(16'h0610, 16'h0611);
      issue(1'b0, 0, 0, 1'b1, I_ADD, 16'h0600, 0, 0, 0);
      check("flush_before_reset", flush, 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("async_reset_flush", flush, 64'd0);
      check("async_reset_counts", {branch_count, mispredict_count}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_abort", fetch_ready, 64'd1);
      issue(1'b0, 0, 0, 1'b1, I_ADD, 16'h0610, 0, 0, 0);
      check("queue_dropped_by_reset", sync_err, 64'd1);

      idle();
      check("scoreboard_drained", sb.size(), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
